// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch and the load/store datapath.
// Data has fixed priority, except that fetch is forced through after MAX_WAIT stalled cycles.
module ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dp_req,
  input  logic              i_dp_we,
  input  logic [ADDR_W-1:0] i_dp_addr,
  input  logic [DATA_W-1:0] i_dp_wdata,
  output logic              o_dp_gnt,
  output logic              o_dp_rvalid,
  output logic [DATA_W-1:0] o_dp_rdata,
  output logic              o_ram_set,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  input  logic [DATA_W-1:0] i_ram_data
);

  typedef enum logic {
    PRIO_DATA,
    PRIO_FETCH
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_nxt;
  logic              if_gnt, dp_gnt;
  logic              if_vld_p1, dp_vld_p1;
  logic [DATA_W-1:0] if_rdata_p1, dp_rdata_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + 4'd1;
  endfunction

  always_comb begin
    if_gnt    = 1'b0;
    dp_gnt    = 1'b0;
    wait_nxt  = '0;
    state_nxt = state;
    if (i_rst_n) begin
      case (state)
        PRIO_FETCH: begin
          if (i_if_req)      if_gnt = 1'b1;
          else if (i_dp_req) dp_gnt = 1'b1;
        end
        default: begin
          if (i_dp_req)      dp_gnt = 1'b1;
          else if (i_if_req) if_gnt = 1'b1;
        end
      endcase

      wait_nxt = (i_if_req && !if_gnt) ? sat_inc(wait_cnt) : 4'd0;

      case (state)
        PRIO_FETCH: if (if_gnt || !i_if_req) state_nxt = PRIO_DATA;
        default:    if (wait_nxt == WAIT_MAX) state_nxt = PRIO_FETCH;
      endcase
    end
  end

  always_comb begin
    o_ram_set  = 1'b0;
    o_ram_addr = '0;
    o_ram_data = '0;
    if (dp_gnt) begin
      o_ram_set  = i_dp_we;
      o_ram_addr = i_dp_addr;
      o_ram_data = i_dp_wdata;
    end else if (if_gnt) begin
      o_ram_addr = i_if_addr;
    end
  end

  // p0 -> p1: read data registered towards the winning requester
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= PRIO_DATA;
      wait_cnt    <= '0;
      if_vld_p1   <= 1'b0;
      dp_vld_p1   <= 1'b0;
      if_rdata_p1 <= '0;
      dp_rdata_p1 <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      if_vld_p1 <= if_gnt;
      dp_vld_p1 <= dp_gnt && !i_dp_we;
      if (if_gnt)               if_rdata_p1 <= i_ram_data;
      if (dp_gnt && !i_dp_we)   dp_rdata_p1 <= i_ram_data;
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_dp_gnt    = dp_gnt;
  assign o_if_rvalid = if_vld_p1;
  assign o_if_rdata  = if_rdata_p1;
  assign o_dp_rvalid = dp_vld_p1;
  assign o_dp_rdata  = dp_rdata_p1;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter that shares the single-port 32-bit program/data RAM between the instruction-fetch unit and the load/store datapath.
- Grants at most one access per cycle and drives the RAM address, write-enable and write-data lines.
- Captures RAM read data into a registered response returned to the winning requester one cycle later.
- Uses fixed data-port priority with a bounded-starvation override, so fetch is never blocked for more than MAX_WAIT consecutive cycles.

Parameters:
ADDR_W, 16, RAM word-address width
DATA_W, 32, RAM word width
MAX_WAIT, 4, max consecutive cycles fetch may request without grant before forced fetch priority (legal range 1..15)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_if_req  input  1  fetch read request; held until o_if_gnt
i_if_addr  input  ADDR_W  fetch word address; stable while i_if_req high
o_if_gnt  output  1  fetch granted this cycle (combinational)
o_if_rvalid  output  1  fetch read data valid (registered, 1-cycle pulse)
o_if_rdata  output  DATA_W  fetch read data (registered)
i_dp_req  input  1  datapath request; held until o_dp_gnt
i_dp_we  input  1  1 = write, 0 = read
i_dp_addr  input  ADDR_W  datapath word address
i_dp_wdata  input  DATA_W  datapath write data
o_dp_gnt  output  1  datapath granted this cycle (combinational)
o_dp_rvalid  output  1  datapath read data valid (registered, reads only)
o_dp_rdata  output  DATA_W  datapath read data (registered)
o_ram_set  output  1  RAM write enable
o_ram_addr  output  ADDR_W  RAM address
o_ram_data  output  DATA_W  RAM write data
i_ram_data  input  DATA_W  RAM combinational read data

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - o_if_rvalid, o_dp_rvalid, o_if_rdata, o_dp_rdata cleared to 0.
  - FSM forced to PRIO_DATA; wait counter cleared to 0.
  - Grants and o_ram_set forced to 0 while reset is asserted.
  - Reset mid-transaction drops any pending rvalid; no response is delivered for that access.
- FSM states:
  - PRIO_DATA: if i_dp_req, grant dp; else if i_if_req, grant if.
  - PRIO_FETCH: if i_if_req, grant if; else if i_dp_req, grant dp.
- Wait counter, width 4, saturating at MAX_WAIT:
  - Increments on every cycle i_if_req=1 and o_if_gnt=0.
  - Clears when o_if_gnt=1 or i_if_req=0.
- FSM transitions:
  - PRIO_DATA -> PRIO_FETCH at the edge where the counter's next value equals MAX_WAIT.
  - PRIO_FETCH -> PRIO_DATA on the edge after any fetch grant, or if i_if_req=0.
- Grant exclusivity: o_if_gnt & o_dp_gnt is never 1.
- RAM drive:
  - With no grant: o_ram_addr=0, o_ram_data=0, o_ram_set=0.
  - Fetch grant: o_ram_addr=i_if_addr, o_ram_set=0.
  - Data grant: o_ram_addr=i_dp_addr, o_ram_data=i_dp_wdata, o_ram_set=i_dp_we.
- Read latency is 1 cycle. On the rising edge closing a granted read cycle, i_ram_data is captured into the winner's rdata register and its rvalid goes high for exactly one cycle.
- rdata holds its value until the next read by the same port.
- Writes complete on the grant edge and produce no rvalid.
- Back-to-back grants to the same port are allowed every cycle, giving full throughput of one access per cycle.
- Requester protocol:
  - Dropping req before gnt cancels the request with no side effects.
  - Changing the address while waiting is a protocol violation; the arbiter uses the address presented in the grant cycle.
- Simultaneous events:
  - A request and a pending rvalid for the same port coexist; rvalid refers to the previous grant.
  - Both requesters asserted in the same cycle are resolved by FSM state, as above.

Test Plan:
- Reset: hold i_rst_n=0 with both req=1 -> both gnt=0, o_ram_set=0, both rvalid=0. Release reset -> first cycle grants dp.
- Single fetch read: preload RAM[5]=0xDEADBEEF; i_if_req=1, addr=5 for one cycle -> o_if_gnt same cycle, o_if_rvalid=1 and o_if_rdata=0xDEADBEEF next cycle, rvalid=0 the cycle after.
- Write then read: dp write addr=3, data=0x12345678, then dp read addr=3 -> o_ram_set=1 only in cycle 1, o_dp_rvalid=1 with o_dp_rdata=0x12345678 in cycle 3, no rvalid in cycle 2.
- Starvation bound: i_dp_req and i_if_req held continuously, MAX_WAIT=4 -> dp granted cycles 0-3, if granted cycle 4, dp cycles 5-8, if cycle 9; fetch never waits more than 4 cycles.
- Cancel: i_if_req high 2 cycles while dp busy, then dropped -> no if grant, counter back to 0, subsequent if request waits a fresh 4 cycles.
- Reset mid-read: dp read granted, i_rst_n pulsed low before the next edge completes -> o_dp_rvalid stays 0, FSM returns to PRIO_DATA.
